nios_soc_led_ctrl: RTL and testbench

NIOS_SOC_LED_CTRL -- requirements
Module: nios_soc_led_ctrl

---
 rtl/nios_soc_led_ctrl_pkg.sv | 15 +
 rtl/nios_soc_led_blink_timer.sv | 35 +++
 rtl/nios_soc_led_ctrl.sv | 106 ++++++++++
 tb/tb_nios_soc_led_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_soc_led_ctrl_pkg.sv
// Shared constants for the LED/PIO controller: the register word addresses
// and the default channel-count and prescaler-width values.
package nios_soc_led_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 14;
  localparam int DEFAULT_DIV_W = 24;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/nios_soc_led_blink_timer.sv
// Blink prescaler shared by every blink channel. A down-counter reloads from
// `period` when it reaches zero and toggles `phase`, so each phase level lasts
// period+1 cycles. A `load` pulse restarts the count from `period` with
// phase high, and it wins over a terminal count on the same edge.
module nios_soc_led_blink_timer
  import nios_soc_led_ctrl_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             phase
);

  logic [DIV_W-1:0] count;

  // Counter and phase: reset, explicit reload, terminal reload+toggle, count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '1;
      phase <= 1'b1;
    end else if (load) begin
      count <= period;
      phase <= 1'b1;
    end else if (count == '0) begin
      count <= period;
      phase <= ~phase;
    end else begin
      count <= count - DIV_W'(1);
    end
  end

endmodule

// File: rtl/nios_soc_led_ctrl.sv
// Avalon-MM LED/PIO controller with optional per-channel blinking.
// Build option: define NIOS_SOC_LED_CTRL_BLINK_EN to include the MODE and
// PERIOD registers and the shared blink prescaler; without it out_port is
// simply DATA and addresses 1-2 read as zero and ignore writes.
//
// Bus handshake: Avalon-MM slave with no waitrequest. A write is accepted on
// every rising edge where chipselect=1 and write_n=0. Reads are zero-wait
// combinational from address and register state only (chipselect ignored).
module nios_soc_led_ctrl
  import nios_soc_led_ctrl_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter int          DIV_W       = DEFAULT_DIV_W,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] status;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  // DATA register: direct write plus bitwise set/clear aliases.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE[WIDTH-1:0];
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_q <= wr_bits;
        ADDR_OUTSET:   data_q <= data_q | wr_bits;
        ADDR_OUTCLEAR: data_q <= data_q & ~wr_bits;
        default:       ;
      endcase
    end
  end

`ifdef NIOS_SOC_LED_CTRL_BLINK_EN
  logic [WIDTH-1:0] mode_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] timer_period;
  logic             period_wr;
  logic             phase;

  assign period_wr = wr_en && (address == ADDR_PERIOD);

  // MODE and PERIOD registers; neither touches the prescaler except a PERIOD write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      period_q <= '1;
    end else if (wr_en) begin
      if (address == ADDR_MODE)   mode_q   <= wr_bits;
      if (address == ADDR_PERIOD) period_q <= writedata[DIV_W-1:0];
    end
  end

  // On a PERIOD write the timer must load the new value, not the stale register.
  assign timer_period = period_wr ? writedata[DIV_W-1:0] : period_q;

  nios_soc_led_blink_timer #(
    .DIV_W (DIV_W)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (period_wr),
    .period (timer_period),
    .phase  (phase)
  );

  assign status = data_q & (~mode_q | {WIDTH{phase}});
`else
  assign status = data_q;
`endif

  assign out_port = status;

  // Read mux: zero-extended register views; write-only and reserved read zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
`ifdef NIOS_SOC_LED_CTRL_BLINK_EN
      ADDR_MODE:   readdata[WIDTH-1:0] = mode_q;
      ADDR_PERIOD: readdata[DIV_W-1:0] = period_q;
`endif
      ADDR_STATUS: readdata[WIDTH-1:0] = status;
      default:     ;
    endcase
  end

  // Upper write-data bits beyond the register widths are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_soc_led_ctrl.sv
// Self-checking bench for nios_soc_led_ctrl (WIDTH=14, DIV_W=24,
// RESET_VALUE=0x15). Follows NIOS_SOC_LED_CTRL_BLINK_EN: blink scenarios run
// when it is defined, the plain-PIO scenario otherwise.
`timescale 1ns/1ps
module tb_nios_soc_led_ctrl;

  localparam int          WIDTH       = 14;
  localparam int          DIV_W       = 24;
  localparam logic [31:0] RESET_VALUE = 32'h0000_0015;
`ifdef NIOS_SOC_LED_CTRL_BLINK_EN
  localparam bit          BLINK       = 1'b1;
`else
  localparam bit          BLINK       = 1'b0;
`endif
  localparam logic [31:0] EXP_RST_PERIOD = BLINK ? 32'h00FF_FFFF : 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'h0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  always #5 clk = ~clk;

  nios_soc_led_ctrl #(
    .WIDTH       (WIDTH),
    .DIV_W       (DIV_W),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase is derived from the number of edges since the last anchor (reset or
  // PERIOD write): it is high for period+1 edges, then low for period+1, etc.
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mode;
  logic [DIV_W-1:0] m_period;
  longint           m_edges;
  bit               m_valid = 1'b0;

  function automatic bit model_phase();
    longint half;
    half = longint'(m_period) + 1;
    return ((m_edges / half) % 2) == 0;
  endfunction

  function automatic logic [WIDTH-1:0] model_out();
    return m_data & (~m_mode | {WIDTH{model_phase()}});
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      3'd0: r = 32'(m_data);
      3'd1: r = 32'(m_mode);
      3'd2: r = BLINK ? 32'(m_period) : 32'h0;
      3'd3: r = 32'(model_out());
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_data   = WIDTH'(RESET_VALUE);
      m_mode   = '0;
      m_period = '1;
      m_edges  = 0;
      m_valid  = 1'b1;
    end else begin
      m_edges = m_edges + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[WIDTH-1:0];
          3'd1: if (BLINK) m_mode = writedata[WIDTH-1:0];
          3'd2: if (BLINK) begin
                  m_period = writedata[DIV_W-1:0];
                  m_edges  = 0;
                end
          3'd4: m_data = m_data | writedata[WIDTH-1:0];
          3'd5: m_data = m_data & ~writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Every-cycle compare of both outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_out_port", 32'(out_port), 32'(model_out()));
      check("cyc_readdata", readdata, model_read(address));
    end
  end

  // ---------------- driver tasks (start/end #1 after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic out_check(input logic [31:0] exp, input string name);
    @(negedge clk);
    check(name, 32'(out_port), exp);
    @(posedge clk);
    #1;
  endtask

  // Sample out_port[0] and STATUS[0] against queued hand-computed levels.
  task automatic blink_samples(input int n, input string name);
    logic [31:0] e;
    address = 3'd3;
    repeat (n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(name, 32'(out_port[0]), e);
      check({name, "_status"}, 32'(readdata[0]), e);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    // Reset state
    out_check(32'h0015, "rst_out_port");
    rd_check(3'd0, 32'h0000_0015, "rst_data");
    rd_check(3'd2, EXP_RST_PERIOD, "rst_period");
    rd_check(3'd1, 32'h0, "rst_mode");

    // DATA write, clear and set aliases, each visible the next cycle
    bus_write(3'd0, 32'h0000_3FFF);
    out_check(32'h3FFF, "wr_data_out");
    bus_write(3'd5, 32'h0000_000F);
    out_check(32'h3FF0, "outclear_out");
    bus_write(3'd4, 32'h0000_0001);
    out_check(32'h3FF1, "outset_out");
    rd_check(3'd0, 32'h0000_3FF1, "set_clr_data");
    rd_check(3'd4, 32'h0, "rd_outset");
    rd_check(3'd5, 32'h0, "rd_outclear");
    rd_check(3'd6, 32'h0, "rd_rsvd6");

    // Ignored writes: STATUS, reserved, and a write_n low without chipselect
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'h0000_0000);
    bus_write(3'd7, 32'h0000_0000);
    address = 3'd0; writedata = 32'h0; write_n = 1'b0;
    idle(1);
    write_n = 1'b1;
    rd_check(3'd0, 32'h0000_3FF1, "ignored_writes");

    // Upper write bits dropped
    bus_write(3'd0, 32'hFFFF_C0A5);
    rd_check(3'd0, 32'h0000_00A5, "wide_write");

`ifdef NIOS_SOC_LED_CTRL_BLINK_EN
    // PERIOD=3: bit0 blinks 4 high / 4 low, bit1 steady
    bus_write(3'd1, 32'h0000_0001);
    bus_write(3'd0, 32'h0000_0003);
    bus_write(3'd2, 32'h0000_0003);
    for (int i = 0; i < 16; i++) exp_q.push_back(((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
    blink_samples(16, "blink_p3");
    // Terminal count due on the edge of the PERIOD=1 rewrite: reload wins
    idle(3);
    bus_write(3'd2, 32'h0000_0001);
    for (int i = 0; i < 6; i++) exp_q.push_back(((i / 2) % 2 == 0) ? 32'd1 : 32'd0);
    blink_samples(6, "reload_p1");
    rd_check(3'd2, 32'h0000_0001, "period_rd");

    // PERIOD=0: four blink channels toggle together every cycle
    bus_write(3'd0, 32'h0000_3FFF);
    bus_write(3'd1, 32'h0000_00F0);
    bus_write(3'd2, 32'h0000_0000);
    out_check(32'h3FFF, "p0_n0");
    out_check(32'h3F0F, "p0_n1");
    out_check(32'h3FFF, "p0_n2");
    out_check(32'h3F0F, "p0_n3");

    // Reset coincident with a DATA write mid-blink
    address = 3'd0; writedata = 32'h0000_1234; chipselect = 1'b1; write_n = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd_check(3'd0, 32'h0000_0015, "rst_wr_data");
    rd_check(3'd1, 32'h0, "rst_wr_mode");
    bus_write(3'd1, 32'h0000_0001);
    rd_check(3'd3, 32'h0000_0015, "rst_wr_phase");
`else
    // No blink hardware: MODE/PERIOD read zero, out_port follows DATA only
    bus_write(3'd1, 32'h0000_3FFF);
    bus_write(3'd0, 32'h0000_00AA);
    rd_check(3'd1, 32'h0, "noblink_mode");
    bus_write(3'd2, 32'h0000_0005);
    rd_check(3'd2, 32'h0, "noblink_period");
    for (int i = 0; i < 8; i++) out_check(32'h00AA, "noblink_out");
    rd_check(3'd3, 32'h0000_00AA, "noblink_status");

    // Reset coincident with a DATA write
    address = 3'd0; writedata = 32'h0000_1234; chipselect = 1'b1; write_n = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd_check(3'd0, 32'h0000_0015, "rst_wr_data");
    out_check(32'h0015, "rst_wr_out");
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
